// File: rtl/naive_bus_wr_buffer.sv
// Posted-write buffer between a naive_bus master and the downstream slave/arbiter.
// Define NAIVE_BUS_WRBUF_ADDR_MATCH_EN to let non-aliasing reads bypass buffered writes.
module naive_bus_wr_buffer #(
  parameter int DEPTH_LOG = 2
) (
  input  logic        clk,
  input  logic        rst,
  // upstream (slave side)
  input  logic        bus_s_rd_req,
  output logic        bus_s_rd_gnt,
  input  logic [31:0] bus_s_rd_addr,
  input  logic [3:0]  bus_s_rd_be,
  output logic [31:0] bus_s_rd_data,
  input  logic        bus_s_wr_req,
  output logic        bus_s_wr_gnt,
  input  logic [31:0] bus_s_wr_addr,
  input  logic [3:0]  bus_s_wr_be,
  input  logic [31:0] bus_s_wr_data,
  // downstream (master side)
  output logic        bus_m_rd_req,
  input  logic        bus_m_rd_gnt,
  output logic [31:0] bus_m_rd_addr,
  output logic [3:0]  bus_m_rd_be,
  input  logic [31:0] bus_m_rd_data,
  output logic        bus_m_wr_req,
  input  logic        bus_m_wr_gnt,
  output logic [31:0] bus_m_wr_addr,
  output logic [3:0]  bus_m_wr_be,
  output logic [31:0] bus_m_wr_data,
  output logic        wbuf_empty
);

  // Handshake: a transfer happens in any cycle where req and gnt are both high.
  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [DEPTH_LOG:0]   wptr;
  logic [DEPTH_LOG:0]   rptr;
  logic [31:0]          addr_mem [DEPTH];
  logic [3:0]           be_mem   [DEPTH];
  logic [31:0]          data_mem [DEPTH];
  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 rd_ok;
  logic [DEPTH_LOG-1:0] head;

  // Flags derive purely from the pointer flops, so they behave as registered.
  assign empty = (wptr == rptr);
  assign full  = (wptr[DEPTH_LOG-1:0] == rptr[DEPTH_LOG-1:0]) &&
                 (wptr[DEPTH_LOG] != rptr[DEPTH_LOG]);
  assign head  = rptr[DEPTH_LOG-1:0];

  assign bus_s_wr_gnt = bus_s_wr_req && !full && !rst;
  assign push         = bus_s_wr_gnt;
  assign bus_m_wr_req = !empty;
  assign pop          = bus_m_wr_req && bus_m_wr_gnt;
  assign wbuf_empty   = empty;

  assign bus_m_wr_addr = addr_mem[head];
  assign bus_m_wr_be   = be_mem[head];
  assign bus_m_wr_data = data_mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr[DEPTH_LOG-1:0]] <= bus_s_wr_addr;
      be_mem[wptr[DEPTH_LOG-1:0]]   <= bus_s_wr_be;
      data_mem[wptr[DEPTH_LOG-1:0]] <= bus_s_wr_data;
    end
  end

`ifdef NAIVE_BUS_WRBUF_ADDR_MATCH_EN
  logic [DEPTH_LOG:0] count;
  logic               rd_hit;
  logic [DEPTH_LOG:0] slot;

  assign count = wptr - rptr;

  // Scan only occupied slots (offset from head below count); a push this cycle is not visible.
  always_comb begin
    rd_hit = 1'b0;
    slot   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rptr + (DEPTH_LOG + 1)'(i);
      if (((DEPTH_LOG + 1)'(i) < count) &&
          (addr_mem[slot[DEPTH_LOG-1:0]][31:2] == bus_s_rd_addr[31:2]) &&
          ((be_mem[slot[DEPTH_LOG-1:0]] & bus_s_rd_be) != 4'b0000))
        rd_hit = 1'b1;
    end
  end

  assign rd_ok = !rd_hit;
`else
  assign rd_ok = empty;
`endif

  assign bus_m_rd_req  = bus_s_rd_req && rd_ok;
  assign bus_m_rd_addr = bus_s_rd_addr;
  assign bus_m_rd_be   = bus_s_rd_be;
  assign bus_s_rd_gnt  = bus_m_rd_gnt && rd_ok && !rst;
  assign bus_s_rd_data = bus_m_rd_data;

endmodule
